// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_SEL_REG   = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

  // One comparator per source operand (rs1, rs2).
  localparam int NUM_OPS = 2;

  typedef enum logic {
    PIPE_ST_RUN      = 1'b0,
    PIPE_ST_MEM_WAIT = 1'b1
  } pipe_st_e;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Per-operand comparator: matches one ID source register against the EX/MEM/WB
// shadows and reports load-use, any-RAW and the forwarding source select.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] raddr,
  input  logic                      ex_vld,
  input  logic                      ex_wen,
  input  logic                      ex_mem2reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_waddr,
  input  logic                      mem_vld,
  input  logic                      mem_wen,
  input  logic                      mem_mem2reg,
  input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
  input  logic                      wb_vld,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic                      ld_hit,
  output logic                      raw_hit,
  output logic [1:0]                sel
);

  logic rd_nz, ex_eq, mem_eq, wb_eq;
  logic ex_raw, mem_raw, wb_raw;

  always_comb begin
    // A nonzero raddr that matches implies a nonzero waddr, so x0 never hits.
    rd_nz   = |raddr;
    ex_eq   = rd_nz && (ex_waddr  == raddr);
    mem_eq  = rd_nz && (mem_waddr == raddr);
    wb_eq   = rd_nz && (wb_waddr  == raddr);
    ex_raw  = ex_vld  && ex_wen  && ex_eq;
    mem_raw = mem_vld && mem_wen && mem_eq;
    wb_raw  = wb_vld  && wb_wen  && wb_eq;
    ld_hit  = ex_vld && ex_mem2reg && ex_eq;
    raw_hit = ex_raw || mem_raw || wb_raw;
    sel     = FWD_SEL_REG;
    if (mem_raw && !mem_mem2reg) sel = FWD_SEL_EXMEM;
    else if (wb_raw)             sel = FWD_SEL_MEMWB;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Build option: define PIPE_CTRL_FWD_EN to enable operand forwarding; without it
// every RAW hazard against EX/MEM/WB stalls the front end.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_WAIT_MAX   = 15,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg1_raddr,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg2_raddr,
  input  logic                      id_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg_waddr,
  input  logic                      id_mem2reg,
  input  logic                      id_mem_acc,
  input  logic                      ex_redirect,
  input  logic                      mem_ready,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic                      ex_mem_stall,
  output logic                      mem_wb_bubble,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      mem_timeout
);

  typedef struct packed {
    logic                      vld;
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic                      mem2reg;
    logic                      mem_acc;
  } xm_shd_t;

  typedef struct packed {
    logic                      vld;
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] waddr;
  } wb_shd_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_MAX = CNT_WIDTH'(MEM_WAIT_MAX);

  pipe_st_e             st_q, st_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  xm_shd_t              ex_q, ex_d, mem_q, mem_d;
  wb_shd_t              wb_q, wb_d;

  logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0] raddr;
  logic [NUM_OPS-1:0]                     ld_hit, raw_hit;
  logic [NUM_OPS-1:0][1:0]                sel, fwd_sel;

  logic mem_busy, mem_hold, mem_to, redir, haz, front_stall, bubble;

  assign raddr = {id_reg2_raddr, id_reg1_raddr};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    pipe_fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
      .raddr      (raddr[i]),
      .ex_vld     (ex_q.vld),
      .ex_wen     (ex_q.wen),
      .ex_mem2reg (ex_q.mem2reg),
      .ex_waddr   (ex_q.waddr),
      .mem_vld    (mem_q.vld),
      .mem_wen    (mem_q.wen),
      .mem_mem2reg(mem_q.mem2reg),
      .mem_waddr  (mem_q.waddr),
      .wb_vld     (wb_q.vld),
      .wb_wen     (wb_q.wen),
      .wb_waddr   (wb_q.waddr),
      .ld_hit     (ld_hit[i]),
      .raw_hit    (raw_hit[i]),
      .sel        (sel[i])
    );
  end

`ifdef PIPE_CTRL_FWD_EN
  logic [NUM_OPS-1:0] unused_raw_hit;
  assign unused_raw_hit = raw_hit;
  assign haz            = id_valid && (|ld_hit);
  assign fwd_sel        = sel;
`else
  logic [NUM_OPS-1:0][1:0] unused_fwd_sel;
  assign unused_fwd_sel = sel;
  assign haz            = id_valid && (|(raw_hit | ld_hit));
  assign fwd_sel        = '0;
`endif

  // MEM holds an access the memory has not acknowledged yet.
  assign mem_busy = mem_q.vld && mem_q.mem_acc && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= PIPE_ST_RUN;
      cnt_q <= '0;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Counter holds the number of wait cycles already spent, including the
  // detection cycle in RUN, so the timeout lands on wait cycle MEM_WAIT_MAX+1.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      PIPE_ST_RUN: begin
        if (mem_busy) begin
          st_d  = PIPE_ST_MEM_WAIT;
          cnt_d = CNT_WIDTH'(1);
        end
      end
      PIPE_ST_MEM_WAIT: begin
        if (!mem_ready && (cnt_q != WAIT_MAX)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
          st_d  = PIPE_ST_RUN;
          cnt_d = '0;
        end
      end
      default: begin
        st_d  = PIPE_ST_RUN;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_hold = 1'b0;
    mem_to   = 1'b0;
    case (st_q)
      PIPE_ST_RUN:      mem_hold = mem_busy;
      PIPE_ST_MEM_WAIT: begin
        mem_hold = !mem_ready;
        mem_to   = !mem_ready && (cnt_q == WAIT_MAX);
      end
      default: ;
    endcase
  end

  // Redirect waits while EX is frozen and wins over any front-end stall.
  assign redir       = ex_redirect && !mem_hold;
  assign front_stall = haz && !redir && !mem_hold;
  assign bubble      = redir || front_stall;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_hold) begin
      ex_d.vld     = id_valid && !bubble;
      ex_d.wen     = id_reg_wen;
      ex_d.waddr   = id_reg_waddr;
      ex_d.mem2reg = id_mem2reg;
      ex_d.mem_acc = id_mem_acc;
      mem_d        = ex_q;
      wb_d.vld     = mem_q.vld;
      wb_d.wen     = mem_q.wen;
      wb_d.waddr   = mem_q.waddr;
    end else begin
      // MEM/WB takes a NOP while MEM is held; a timeout also drops MEM.
      wb_d.vld = 1'b0;
      if (mem_to) mem_d.vld = 1'b0;
    end
  end

  always_comb begin
    pc_stall      = rst_n && (mem_hold || front_stall);
    if_id_stall   = rst_n && (mem_hold || front_stall);
    if_id_flush   = rst_n && redir;
    id_ex_bubble  = rst_n && bubble;
    ex_mem_stall  = rst_n && mem_hold;
    mem_wb_bubble = rst_n && mem_hold;
    mem_timeout   = rst_n && mem_to;
    fwd_a_sel     = rst_n ? fwd_sel[0] : FWD_SEL_REG;
    fwd_b_sel     = rst_n ? fwd_sel[1] : FWD_SEL_REG;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios for pipe_ctrl; expected output vectors are queued per
// driven cycle and compared half a cycle later.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_reg_wen, id_mem2reg, id_mem_acc, ex_redirect, mem_ready;
  logic [4:0] id_reg1_raddr, id_reg2_raddr, id_reg_waddr;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_wb_bubble, mem_timeout;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_ADDR_WIDTH(5), .MEM_WAIT_MAX(15), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_reg1_raddr(id_reg1_raddr), .id_reg2_raddr(id_reg2_raddr),
    .id_reg_wen(id_reg_wen), .id_reg_waddr(id_reg_waddr),
    .id_mem2reg(id_mem2reg), .id_mem_acc(id_mem_acc),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_timeout(mem_timeout)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_wb_bubble, mem_timeout, fwd_a, fwd_b}
  logic [10:0] obs;
  assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
                mem_wb_bubble, mem_timeout, fwd_a_sel, fwd_b_sel};

  localparam logic [10:0] E_NONE = 11'b00000000000;
  localparam logic [10:0] E_HAZ  = 11'b11010000000;
  localparam logic [10:0] E_RDR  = 11'b00110000000;
  localparam logic [10:0] E_WAIT = 11'b11001100000;
  localparam logic [10:0] E_TO   = 11'b11001110000;
`ifdef PIPE_CTRL_FWD_EN
  localparam logic [10:0] E_FA10 = 11'b00000001000;
  localparam logic [10:0] E_F11  = 11'b00000000101;
`endif

  typedef struct packed {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic wen; logic [4:0] rd;
    logic ld; logic ma; logic redir; logic rdy;
  } stim_t;

  typedef struct { stim_t s; logic [10:0] e; } row_t;

  row_t        rows[$];
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic stim_t mk(int v, int rs1, int rs2, int wen, int rd, int ld, int ma, int redir, int rdy);
    stim_t s;
    s.v = v[0]; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.wen = wen[0]; s.rd = 5'(rd);
    s.ld = ld[0]; s.ma = ma[0]; s.redir = redir[0]; s.rdy = rdy[0];
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; id_reg1_raddr = s.rs1; id_reg2_raddr = s.rs2;
    id_reg_wen = s.wen; id_reg_waddr = s.rd; id_mem2reg = s.ld; id_mem_acc = s.ma;
    ex_redirect = s.redir; mem_ready = s.rdy;
  endtask

  task automatic row(input stim_t s, input logic [10:0] e);
    row_t r;
    r.s = s; r.e = e;
    rows.push_back(r);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), E_NONE);
  endtask

  task automatic test_reset();
    logic [10:0] want;
    rst_n = 1'b0;
    drive(mk(1, 5, 5, 1, 5, 1, 1, 1, 0));
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(E_NONE);
      @(negedge clk);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL reset_hold[%0d]: got %b expected %b", k, obs, want); end
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_n = 1'b1;
    rows.delete(); nops(2);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  task automatic test_load_use();
    logic [10:0] want;
    rows.delete();
    row(mk(1, 1, 0, 1, 5, 1, 1, 0, 1), E_NONE);   // lw x5,0(x1)
    row(mk(1, 5, 2, 1, 6, 0, 0, 0, 1), E_HAZ);    // add x6,x5,x2
`ifdef PIPE_CTRL_FWD_EN
    row(mk(1, 5, 2, 1, 6, 0, 0, 0, 1), E_NONE);
    row(mk(1, 5, 6, 1, 7, 0, 0, 0, 1), E_FA10);   // or x7,x5,x6: lw now in WB
`else
    row(mk(1, 5, 2, 1, 6, 0, 0, 0, 1), E_HAZ);
    row(mk(1, 5, 2, 1, 6, 0, 0, 0, 1), E_HAZ);
    row(mk(1, 5, 2, 1, 6, 0, 0, 0, 1), E_NONE);
`endif
    nops(3);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  task automatic test_raw();
    logic [10:0] want;
    rows.delete();
`ifdef PIPE_CTRL_FWD_EN
    row(mk(1, 1, 2, 1, 3, 0, 0, 0, 1), E_NONE);   // add x3,x1,x2
    row(mk(1, 1, 2, 1, 3, 0, 0, 0, 1), E_NONE);   // add x3,x1,x2 again
    nops(1);
    row(mk(1, 3, 3, 1, 4, 0, 0, 0, 1), E_F11);    // sub x4,x3,x3: MEM beats WB
`else
    row(mk(1, 1, 2, 1, 3, 0, 0, 0, 1), E_NONE);
    for (int k = 0; k < 3; k++) row(mk(1, 3, 3, 1, 4, 0, 0, 0, 1), E_HAZ);
    row(mk(1, 3, 3, 1, 4, 0, 0, 0, 1), E_NONE);
`endif
    nops(3);
    row(mk(1, 1, 2, 1, 0, 0, 0, 0, 1), E_NONE);   // add x0,x1,x2
    nops(1);
    row(mk(1, 0, 0, 1, 4, 0, 0, 0, 1), E_NONE);   // sub x4,x0,x0
    nops(3);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL raw_pair[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  task automatic test_redirect();
    logic [10:0] want;
    rows.delete();
    row(mk(1, 1, 0, 1, 5, 1, 1, 0, 1), E_NONE);   // lw x5
    row(mk(1, 5, 2, 1, 6, 0, 0, 1, 1), E_RDR);    // dependent add, branch taken in EX
    nops(3);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL redirect[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  task automatic test_mem_wait();
    logic [10:0] want;
    rows.delete();
    row(mk(1, 1, 2, 0, 0, 0, 1, 0, 1), E_NONE);   // sw x2,0(x1)
    row(mk(1, 1, 2, 0, 0, 0, 0, 0, 1), E_NONE);   // beq x1,x2
    for (int k = 0; k < 3; k++) row(mk(1, 3, 4, 1, 7, 0, 0, 1, 0), E_WAIT);
    row(mk(1, 3, 4, 1, 7, 0, 0, 1, 1), E_RDR);    // release honours held redirect
    nops(3);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] want;
    rows.delete();
    row(mk(1, 1, 0, 1, 9, 1, 1, 0, 1), E_NONE);   // lw x9
    nops(1);
    for (int k = 0; k < 15; k++) row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_WAIT);
    row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_TO);     // wait cycle 16
    row(mk(1, 9, 0, 1, 10, 0, 0, 0, 1), E_NONE);  // squashed lw must not cause a hazard
    nops(3);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [10:0] want;
    rows.delete();
    row(mk(1, 1, 0, 1, 5, 1, 1, 0, 1), E_NONE);
    nops(1);
    row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_WAIT);
    row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_WAIT);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL rst_wait_pre[%0d]: got %b expected %b", i, obs, want); end
    end
    #2;
    drive(mk(1, 5, 0, 1, 6, 0, 0, 1, 0));
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin @(posedge clk); end
      #1;
      exp_q.push_back(E_NONE);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL rst_async[%0d]: got %b expected %b", k, obs, want); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    rows.delete();
    row(mk(1, 5, 0, 1, 6, 0, 0, 0, 0), E_NONE);   // shadows empty, FSM in RUN
    row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE);
    nops(3);
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].s); exp_q.push_back(rows[i].e);
      @(negedge clk); want = exp_q.pop_front(); checks++;
      if (obs !== want) begin errors++; $display("FAIL rst_wait_post[%0d]: got %b expected %b", i, obs, want); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_raw();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
